mem_arbiter: RTL
================

# mem_arbiter

Two-to-one arbiter that shares a single unified memory bus between the core's instruction-fetch port and data-access port. It sits between `core` and a single-ported memory or interconnect. It accepts pipelined request/grant/rvalid transactions from both requesters and gives data accesses priority, with a starvation guard for fetches. It tracks up to `MAX_OUTSTANDING` in-flight transactions and routes each in-order response back to the requester that issued it.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum granted transactions awaiting `mem_rvalid_i`; legal range 1..8.
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while a fetch is pending before the fetch is forced; legal range 1..15.
- `clk_i`  in  1  clock; all state on the rising edge.
- `rst_n_i`  in  1  reset; asynchronous and active-low (already decided).
- `instr_req_i`  in  1  fetch request.
- `instr_addr_i`  in  32  fetch address.
- `instr_gnt_o`  out  1  fetch accepted this cycle.
- `instr_rvalid_o`  out  1  fetch response valid.
- `instr_rdata_o`  out  32  fetch read data.
- `data_req_i`  in  1  data request.
- `data_addr_i`  in  32  data address.
- `data_we_i`  in  1  write enable.
- `data_be_i`  in  4  byte enables.
- `data_wdata_i`  in  32  write data.
- `data_gnt_o`  out  1  data request accepted.
- `data_rvalid_o`  out  1  data response valid; asserted for both reads and writes.
- `data_rdata_o`  out  32  data read data.
- `mem_req_o`  out  1  bus request.
- `mem_addr_o`  out  32  bus address.
- `mem_we_o`  out  1  bus write enable.
- `mem_be_o`  out  4  bus byte enables.
- `mem_wdata_o`  out  32  bus write data.
- `mem_gnt_i`  in  1  bus accepted request.
- `mem_rvalid_i`  in  1  bus response valid.
- `mem_rdata_i`  in  32  bus response data.
- `resp_err_o`  out  1  one-cycle pulse when `mem_rvalid_i` arrives with no outstanding transaction.

## Operation
- **Request path.** `mem_req_o` = (`instr_req_i` | `data_req_i`) & !full & !rst.
  - The selected source drives `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wdata_o`.
  - For fetches: `mem_we_o` = 0, `mem_be_o` = 4'hF, `mem_wdata_o` = 0.
- **Selection.**
  - When not locked, data wins if `data_req_i` is high, unless `starve_cnt_q` == `STARVE_LIMIT` and `instr_req_i` is high, in which case the fetch wins.
  - `starve_cnt_q`: increments on each data grant while `instr_req_i` is high; clears on any fetch grant or when `instr_req_i` is low; saturates at `STARVE_LIMIT`.
- **Lock.**
  - If `mem_req_o` is high and `mem_gnt_i` is low, the current selection is registered (`lock_q` = 1, `lock_sel_q`) and held until granted.
  - While locked, the bus signals must not change, even if the other requester raises its request.
  - Requesters must hold their request until granted.
- **Grant.** `instr_gnt_o` / `data_gnt_o` = `mem_gnt_i` & `mem_req_o` & (selected source). Exactly one is high per grant.
- **Source FIFO.**
  - On each handshake (`mem_req_o` & `mem_gnt_i`), push the source ID.
  - On `mem_rvalid_i` with the FIFO non-empty, pop the head and route the response:
    - Head = INSTR: `instr_rvalid_o` = 1.
    - Head = DATA: `data_rvalid_o` = 1.
  - `instr_rdata_o` and `data_rdata_o` both carry `mem_rdata_i` unconditionally.
- **Full.** count == `MAX_OUTSTANDING` blocks `mem_req_o`, even if a pop occurs in the same cycle. This is conservative and keeps the request path free of a combinational path from `mem_rvalid_i`.
- **Push and pop in the same cycle:** count is unchanged and FIFO order is preserved.
- **Response with FIFO empty:** `mem_rvalid_i` is ignored (both rvalids stay 0) and `resp_err_o` pulses.
- **Reset mid-operation.** All state clears: FIFO empty, count 0, lock 0, `starve_cnt_q` 0. Responses to transactions granted before reset then raise `resp_err_o`.

## Timing
- Request path and grant are combinational: zero-cycle latency from `*_req_i` to `mem_req_o` and from `mem_gnt_i` to `*_gnt_o`.
- Response routing is combinational: `*_rvalid_o` is asserted in the same cycle as `mem_rvalid_i`.
- Register updates (count, FIFO, lock, starve counter) take effect on the next rising edge.
- Reset values:
  - All outputs 0: `mem_req_o`, `*_gnt_o`, `*_rvalid_o` and `resp_err_o` are 0.
  - `mem_addr_o` is 0.
- Throughput: one grant per cycle when `mem_gnt_i` is held high and the FIFO is not full.

## Structure
- Add to `core_pkg`: `typedef enum logic {BUS_SRC_INSTR, BUS_SRC_DATA} bus_src_t`.
- Sub-module `src_fifo`, parameterised by depth:
  - Storage: circular buffer of `bus_src_t`, with read/write pointers and a count of width $clog2(depth+1).
  - Outputs: head, full, empty.
- The top level holds the selection logic, lock register and starvation counter.

## Test plan
1. Fetch only, `mem_gnt_i` = 1, rvalid one cycle later, `mem_rdata_i` = 0x00000013 -> `instr_gnt_o` pulses, then `instr_rvalid_o` = 1 with `instr_rdata_o` = 0x00000013; `data_rvalid_o` stays 0.
2. Simultaneous fetch and data write (addr 0x100, be 4'b0011), `mem_gnt_i` = 1 -> data granted first with `mem_we_o` = 1 and `mem_be_o` = 4'b0011; fetch granted next cycle; responses route DATA then INSTR.
3. `data_req_i` and `instr_req_i` held high continuously, `STARVE_LIMIT` = 4 -> exactly 4 data grants, then 1 fetch grant, repeating.
4. `mem_gnt_i` = 0 for 3 cycles with fetch pending; data request rises in cycle 2 -> `mem_addr_o` stays the fetch address until the grant; data is granted afterwards.
5. `MAX_OUTSTANDING` = 2, grants with no rvalid -> `mem_req_o` drops after 2 grants. One rvalid -> `mem_req_o` returns the next cycle. A push and pop in the same cycle leaves count at 2.
6. `mem_rvalid_i` with empty FIFO, and reset asserted with 2 outstanding followed by 2 rvalids -> `resp_err_o` pulses each time; no `*_rvalid_o` is asserted.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-to-one instruction/data memory arbiter.
// Source IDs are what the response FIFO records, so each reply can be steered back.
package mem_arbiter_pkg;

  typedef enum logic {
    BUS_SRC_INSTR = 1'b0,
    BUS_SRC_DATA  = 1'b1
  } bus_src_t;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam logic [BE_W-1:0] FETCH_BE = 4'hF;

  // A 1-deep buffer still needs a 1-bit pointer to keep the vectors legal.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshake signals around the arbiter.
// slave = arbiter view; master = view of the core plus memory environment.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              instr_req_i;
  logic [ADDR_W-1:0] instr_addr_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [DATA_W-1:0] instr_rdata_o;

  logic              data_req_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic              data_we_i;
  logic [BE_W-1:0]   data_be_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [DATA_W-1:0] data_rdata_o;

  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              resp_err_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output resp_err_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  resp_err_o
  );

endinterface

// File: rtl/mem_arbiter_src_fifo.sv
// Circular buffer of source IDs, one entry per granted, not-yet-answered transaction.
// Pushes while full and pops while empty are ignored; the caller never issues them.
module src_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     i_push,
  input  bus_src_t i_src,
  input  logic     i_pop,
  output bus_src_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  bus_src_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_src;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter sharing one pipelined memory bus between fetch and data ports.
// Data has priority, fetches are forced after STARVE_LIMIT data grants, responses route in order.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned SC_W = 4;
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] r_starve_cnt;
  logic            r_lock;
  bus_src_t        r_lock_sel;

  bus_src_t w_sel;
  bus_src_t w_head;
  logic     w_full;
  logic     w_empty;
  logic     w_req;
  logic     w_handshake;
  logic     w_instr_gnt;
  logic     w_data_gnt;
  logic     w_pop;

  // A stalled request keeps its source so the bus stays stable until accepted.
  always_comb begin
    w_sel = BUS_SRC_INSTR;
    if (r_lock) begin
      w_sel = r_lock_sel;
    end else if (bus.data_req_i &&
                 !((r_starve_cnt == STARVE_MAX) && bus.instr_req_i)) begin
      w_sel = BUS_SRC_DATA;
    end
  end

  assign w_req       = (bus.instr_req_i | bus.data_req_i) & ~w_full & rst_n_i;
  assign w_handshake = w_req & bus.mem_gnt_i;
  assign w_instr_gnt = w_handshake & (w_sel == BUS_SRC_INSTR);
  assign w_data_gnt  = w_handshake & (w_sel == BUS_SRC_DATA);

  // Bus attributes are driven only alongside a live request, zero otherwise.
  always_comb begin
    bus.mem_addr_o  = '0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = '0;
    bus.mem_wdata_o = '0;
    if (w_req) begin
      if (w_sel == BUS_SRC_DATA) begin
        bus.mem_addr_o  = bus.data_addr_i;
        bus.mem_we_o    = bus.data_we_i;
        bus.mem_be_o    = bus.data_be_i;
        bus.mem_wdata_o = bus.data_wdata_i;
      end else begin
        bus.mem_addr_o  = bus.instr_addr_i;
        bus.mem_be_o    = FETCH_BE;
      end
    end
  end

  assign bus.mem_req_o   = w_req;
  assign bus.instr_gnt_o = w_instr_gnt;
  assign bus.data_gnt_o  = w_data_gnt;

  assign w_pop              = rst_n_i & bus.mem_rvalid_i & ~w_empty;
  assign bus.instr_rvalid_o = w_pop & (w_head == BUS_SRC_INSTR);
  assign bus.data_rvalid_o  = w_pop & (w_head == BUS_SRC_DATA);
  assign bus.resp_err_o     = rst_n_i & bus.mem_rvalid_i & w_empty;
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;

  src_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_src_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_push  (w_handshake),
    .i_src   (w_sel),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lock     <= 1'b0;
      r_lock_sel <= BUS_SRC_INSTR;
    end else begin
      r_lock     <= w_req & ~bus.mem_gnt_i;
      r_lock_sel <= w_sel;
    end
  end

  // Counts data grants that overtook a waiting fetch; saturates at the limit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_starve_cnt <= '0;
    end else if (!bus.instr_req_i || w_instr_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_data_gnt && (r_starve_cnt != STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule
